// File: rtl/bitcoin_pkg.sv
// Shared definitions for the hash target checker: default scan length, FSM states and result record layout.
// The extra states WRITE2/WRITE3 exist only when HASH_CHECKER_MIN_TRACK_EN is defined.
package bitcoin_pkg;

    localparam int NUM_NONCES_DEFAULT = 16;

    localparam logic [15:0] REC_FOUND_OFS     = 16'd0;
    localparam logic [15:0] REC_NONCE_OFS     = 16'd1;
    localparam logic [15:0] REC_MIN_HASH_OFS  = 16'd2;
    localparam logic [15:0] REC_MIN_NONCE_OFS = 16'd3;

    localparam logic [31:0] NONCE_NONE = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        READ   = 3'd1,
        WRITE0 = 3'd2,
`ifdef HASH_CHECKER_MIN_TRACK_EN
        WRITE1 = 3'd3,
        WRITE2 = 3'd4,
        WRITE3 = 3'd5
`else
        WRITE1 = 3'd3
`endif
    } state_t;

    // Strict unsigned compare: equal values never qualify.
    function automatic logic hash_below(input logic [31:0] hash, input logic [31:0] limit);
        return (hash < limit);
    endfunction

endpackage

// File: rtl/hash_target_checker.sv
// Scans NUM_NONCES hash words in memory for the first one below target and writes a result record.
// Define HASH_CHECKER_MIN_TRACK_EN to scan every word, track the minimum hash and write a 4-word record.
module hash_target_checker
    import bitcoin_pkg::*;
#(
    parameter int NUM_NONCES = NUM_NONCES_DEFAULT
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [15:0] hash_addr,
    input  logic [15:0] result_addr,
    input  logic [31:0] target,
    output logic        done,
    output logic        found,
    output logic [31:0] nonce,
`ifdef HASH_CHECKER_MIN_TRACK_EN
    output logic [31:0] min_hash,
    output logic [31:0] min_nonce,
`endif
    output logic        mem_clk,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [31:0] mem_write_data,
    input  logic [31:0] mem_read_data
);

    localparam logic [15:0] LAST_IDX = 16'(NUM_NONCES - 1);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [15:0] r_hash_addr;
    logic [15:0] r_result_addr;
    logic [31:0] r_target;
    logic [15:0] r_idx;
    logic        r_valid;
    logic        r_found;
    logic [31:0] r_nonce;
`ifdef HASH_CHECKER_MIN_TRACK_EN
    logic [31:0] r_min_hash;
    logic [31:0] r_min_nonce;
`endif

    logic        w_hit;
    logic        w_last;
    logic        w_scan_end;
    logic        w_mem_we;
    logic [15:0] w_mem_addr;
    logic [31:0] w_mem_wdata;

    // r_valid marks that mem_read_data holds word r_idx (false in the first READ cycle).
    assign w_hit  = r_valid && hash_below(mem_read_data, r_target);
    assign w_last = r_valid && (r_idx == LAST_IDX);
`ifdef HASH_CHECKER_MIN_TRACK_EN
    assign w_scan_end = w_last;
`else
    assign w_scan_end = w_hit || w_last;
`endif

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt = READ;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            READ: begin
                if (w_scan_end) begin
                    w_state_nxt = WRITE0;
                end else begin
                    w_state_nxt = READ;
                end
            end
            WRITE0: w_state_nxt = WRITE1;
`ifdef HASH_CHECKER_MIN_TRACK_EN
            WRITE1: w_state_nxt = WRITE2;
            WRITE2: w_state_nxt = WRITE3;
            WRITE3: w_state_nxt = IDLE;
`else
            WRITE1: w_state_nxt = IDLE;
`endif
            default: w_state_nxt = IDLE;
        endcase
    end

    // Memory port decode; the next read is suppressed combinationally once the scan ends.
    always_comb begin
        w_mem_we    = 1'b0;
        w_mem_addr  = 16'd0;
        w_mem_wdata = 32'd0;
        case (r_state)
            READ: begin
                if (r_valid && !w_scan_end) begin
                    w_mem_addr = r_hash_addr + r_idx + 16'd1;
                end else begin
                    w_mem_addr = r_hash_addr + r_idx;
                end
            end
            WRITE0: begin
                w_mem_we    = 1'b1;
                w_mem_addr  = r_result_addr + REC_FOUND_OFS;
                w_mem_wdata = {31'd0, r_found};
            end
            WRITE1: begin
                w_mem_we    = 1'b1;
                w_mem_addr  = r_result_addr + REC_NONCE_OFS;
                w_mem_wdata = r_nonce;
            end
`ifdef HASH_CHECKER_MIN_TRACK_EN
            WRITE2: begin
                w_mem_we    = 1'b1;
                w_mem_addr  = r_result_addr + REC_MIN_HASH_OFS;
                w_mem_wdata = r_min_hash;
            end
            WRITE3: begin
                w_mem_we    = 1'b1;
                w_mem_addr  = r_result_addr + REC_MIN_NONCE_OFS;
                w_mem_wdata = r_min_nonce;
            end
`endif
            default: begin
                w_mem_we    = 1'b0;
                w_mem_addr  = 16'd0;
                w_mem_wdata = 32'd0;
            end
        endcase
    end

    // Scan datapath: operand latch, word index and result capture.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_hash_addr   <= 16'd0;
            r_result_addr <= 16'd0;
            r_target      <= 32'd0;
            r_idx         <= 16'd0;
            r_valid       <= 1'b0;
            r_found       <= 1'b0;
            r_nonce       <= 32'd0;
`ifdef HASH_CHECKER_MIN_TRACK_EN
            r_min_hash    <= 32'hFFFF_FFFF;
            r_min_nonce   <= 32'd0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_hash_addr   <= hash_addr;
                        r_result_addr <= result_addr;
                        r_target      <= target;
                        r_idx         <= 16'd0;
                        r_valid       <= 1'b0;
                        r_found       <= 1'b0;
                        r_nonce       <= NONCE_NONE;
`ifdef HASH_CHECKER_MIN_TRACK_EN
                        r_min_hash    <= 32'hFFFF_FFFF;
                        r_min_nonce   <= 32'd0;
`endif
                    end
                end
                READ: begin
                    if (!r_valid) begin
                        r_valid <= 1'b1;
                    end else begin
                        if (w_hit && !r_found) begin
                            r_found <= 1'b1;
                            r_nonce <= {16'd0, r_idx};
                        end
`ifdef HASH_CHECKER_MIN_TRACK_EN
                        // Strict compare keeps the lowest index on ties.
                        if ((r_idx == 16'd0) || hash_below(mem_read_data, r_min_hash)) begin
                            r_min_hash  <= mem_read_data;
                            r_min_nonce <= {16'd0, r_idx};
                        end
`endif
                        if (!w_scan_end) begin
                            r_idx <= r_idx + 16'd1;
                        end
                    end
                end
                default: begin
                    r_idx <= r_idx;
                end
            endcase
        end
    end

    assign done           = (r_state == IDLE);
    assign found          = r_found;
    assign nonce          = r_nonce;
`ifdef HASH_CHECKER_MIN_TRACK_EN
    assign min_hash       = r_min_hash;
    assign min_nonce      = r_min_nonce;
`endif
    assign mem_clk        = clk;
    assign mem_we         = w_mem_we;
    assign mem_addr       = w_mem_addr;
    assign mem_write_data = w_mem_wdata;

endmodule

// File: tb/tb_hash_target_checker.sv
// Scoreboard bench for hash_target_checker with a synchronous-read memory model.
// Builds for either setting of HASH_CHECKER_MIN_TRACK_EN.
module tb_hash_target_checker;
    import bitcoin_pkg::*;

    localparam int N = 16;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] hash_addr = 16'd0;
    logic [15:0] result_addr = 16'd0;
    logic [31:0] target = 32'd0;
    logic        done;
    logic        found;
    logic [31:0] nonce;
    logic        mem_clk;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;
`ifdef HASH_CHECKER_MIN_TRACK_EN
    logic [31:0] min_hash;
    logic [31:0] min_nonce;
`endif

    typedef struct {
        logic        found;
        logic [31:0] nonce;
        int          lat;
        int          last;
        logic [31:0] mh;
        logic [31:0] mn;
    } exp_t;

    logic [31:0] mem [0:65535];
    logic [31:0] hv [N];
    logic [15:0] wa_log [$];
    logic [31:0] wd_log [$];
    logic [15:0] rd_log [$];
    exp_t        sb [$];
    int          n_checks = 0;
    int          n_fails = 0;

    hash_target_checker #(.NUM_NONCES(N)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .start         (start),
        .hash_addr     (hash_addr),
        .result_addr   (result_addr),
        .target        (target),
        .done          (done),
        .found         (found),
        .nonce         (nonce),
`ifdef HASH_CHECKER_MIN_TRACK_EN
        .min_hash      (min_hash),
        .min_nonce     (min_nonce),
`endif
        .mem_clk       (mem_clk),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_write_data(mem_write_data),
        .mem_read_data (mem_read_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) mem_read_data <= mem[mem_addr];

    always @(negedge clk) begin
        if (mem_we) begin
            wa_log.push_back(mem_addr);
            wd_log.push_back(mem_write_data);
        end else if (reset_n && !done) begin
            rd_log.push_back(mem_addr);
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [31:0] tgt);
        exp_t e;
        e.found = 1'b0;
        e.nonce = 32'hFFFF_FFFF;
        e.last  = N - 1;
        e.mh    = 32'hFFFF_FFFF;
        e.mn    = 32'd0;
        for (int k = 0; k < N; k++) begin
            if (k == 0 || hv[k] < e.mh) begin
                e.mh = hv[k];
                e.mn = 32'(k);
            end
            if (!e.found && hv[k] < tgt) begin
                e.found = 1'b1;
                e.nonce = 32'(k);
`ifndef HASH_CHECKER_MIN_TRACK_EN
                e.last = k;
                break;
`endif
            end
        end
`ifdef HASH_CHECKER_MIN_TRACK_EN
        e.lat = N + 6;
`else
        e.lat = e.found ? int'(e.nonce) + 5 : N + 4;
`endif
        return e;
    endfunction

    task automatic load_mem(input logic [15:0] base);
        for (int k = 0; k < N; k++) begin
            mem[base + 16'(k)] = hv[k];
        end
    endtask

    task automatic run_scan(input logic [15:0] ha, input logic [15:0] ra,
                            input logic [31:0] tgt, input bit pulse);
        exp_t        e;
        int          n;
        int          wbase;
        int          rbase;
        int          nw;
        int          ew;
        int          viol;
        logic [15:0] off;
        logic [15:0] ea [4];
        logic [31:0] ed [4];
        load_mem(ha);
        sb.push_back(model(tgt));
        @(negedge clk);
        hash_addr = ha; result_addr = ra; target = tgt; start = 1'b1;
        wbase = wa_log.size();
        rbase = rd_log.size();
        @(posedge clk);
        n = 1;
        @(negedge clk);
        start = 1'b0; hash_addr = ~ha; result_addr = ~ra; target = ~tgt;
        while (done !== 1'b1 && n < 200) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            start = (pulse && n == 2);
        end
        start = 1'b0;
        e = sb.pop_front();
        check_eq("done", {31'd0, done}, 32'd1);
        check_eq("latency", 32'(n), 32'(e.lat));
        check_eq("found", {31'd0, found}, {31'd0, e.found});
        check_eq("nonce", nonce, e.nonce);
        ea[0] = ra;         ed[0] = {31'd0, e.found};
        ea[1] = ra + 16'd1; ed[1] = e.nonce;
        ea[2] = ra + 16'd2; ed[2] = e.mh;
        ea[3] = ra + 16'd3; ed[3] = e.mn;
`ifdef HASH_CHECKER_MIN_TRACK_EN
        ew = 4;
        check_eq("min_hash", min_hash, e.mh);
        check_eq("min_nonce", min_nonce, e.mn);
`else
        ew = 2;
`endif
        nw = wa_log.size() - wbase;
        check_eq("write_count", 32'(nw), 32'(ew));
        for (int i = 0; i < ew && i < nw; i++) begin
            check_eq("write_addr", {16'd0, wa_log[wbase + i]}, {16'd0, ea[i]});
            check_eq("write_data", wd_log[wbase + i], ed[i]);
        end
        viol = 0;
        for (int i = rbase; i < rd_log.size(); i++) begin
            off = rd_log[i] - ha;
            if (int'(off) > e.last) viol++;
        end
        check_eq("read_past_end", 32'(viol), 32'd0);
        repeat (2) @(negedge clk);
        check_eq("found_hold", {31'd0, found}, {31'd0, e.found});
        check_eq("nonce_hold", nonce, e.nonce);
    endtask

    task automatic check_reset_values(input string tag);
        check_eq({tag, "_done"}, {31'd0, done}, 32'd1);
        check_eq({tag, "_found"}, {31'd0, found}, 32'd0);
        check_eq({tag, "_nonce"}, nonce, 32'd0);
        check_eq({tag, "_we"}, {31'd0, mem_we}, 32'd0);
        check_eq({tag, "_addr"}, {16'd0, mem_addr}, 32'd0);
        check_eq({tag, "_wdata"}, mem_write_data, 32'd0);
`ifdef HASH_CHECKER_MIN_TRACK_EN
        check_eq({tag, "_min_hash"}, min_hash, 32'hFFFF_FFFF);
        check_eq({tag, "_min_nonce"}, min_nonce, 32'd0);
`endif
    endtask

    initial begin
        int wbase;
        for (int a = 0; a < 65536; a++) mem[a] = 32'hFFFF_FFFF;
        repeat (2) @(negedge clk);
        check_reset_values("reset");
        reset_n = 1'b1;
        @(negedge clk);

        // Early match at word 1; word 2 also qualifies but must not be read.
        for (int k = 0; k < N; k++) hv[k] = 32'hFFFF_FFF0;
        hv[0] = 32'hFFFF_0000; hv[1] = 32'h0000_FFFF; hv[2] = 32'h0000_0001;
        run_scan(16'h0100, 16'h0800, 32'h0001_0000, 1'b0);

        // Equality never qualifies.
        for (int k = 0; k < N; k++) hv[k] = 32'h8000_0000;
        run_scan(16'h0200, 16'h0900, 32'h8000_0000, 1'b0);

        // Match only at the last word, hash region wrapping past 16'hFFFF.
        for (int k = 0; k < N; k++) hv[k] = 32'hFFFF_FFFF;
        hv[N-1] = 32'h0000_0005;
        run_scan(16'hFFF8, 16'h0A00, 32'h0000_0100, 1'b0);

        // Second start pulse during READ is ignored; result record wraps.
        for (int k = 0; k < N; k++) hv[k] = 32'hFFFF_FFF0;
        hv[0] = 32'hFFFF_0000; hv[1] = 32'h0000_FFFF; hv[2] = 32'h0000_0001;
        run_scan(16'h0300, 16'hFFFE, 32'h0001_0000, 1'b1);

        // Reset in cycle 5 of a scan that would otherwise run to the end.
        for (int k = 0; k < N; k++) hv[k] = 32'h8000_0000;
        load_mem(16'h0400);
        @(negedge clk);
        hash_addr = 16'h0400; result_addr = 16'h0B00; target = 32'h0000_0001; start = 1'b1;
        wbase = wa_log.size();
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1 reset_n = 1'b0;
        #1 check_reset_values("midscan_reset");
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (25) @(negedge clk);
        check_eq("no_write_after_reset", 32'(wa_log.size() - wbase), 32'd0);
        check_eq("idle_after_reset", {31'd0, done}, 32'd1);
        run_scan(16'h0400, 16'h0B00, 32'h8000_0001, 1'b0);

        // Minimum tracking pattern with a tie at words 1 and 3.
        for (int k = 0; k < N; k++) hv[k] = 32'd100 + 32'(k);
        hv[0] = 32'd9; hv[1] = 32'd3; hv[2] = 32'd7; hv[3] = 32'd3;
        run_scan(16'h0500, 16'h0C00, 32'd4, 1'b0);

        // Target zero: nothing can qualify.
        run_scan(16'h0500, 16'h0C10, 32'd0, 1'b0);

        // Random scans.
        for (int r = 0; r < 4; r++) begin
            for (int k = 0; k < N; k++) hv[k] = $urandom;
            hv[$urandom_range(0, N - 1)] = 32'($urandom_range(0, 65535));
            run_scan(16'($urandom), 16'h0D00 + 16'(r * 8), 32'($urandom_range(0, 32'h0800_0000)), 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
